tx_fifo_idle_mux: RTL and testbench
===================================

// Module: tx_fifo_idle_mux
// PURPOSE
//   Transmit-side counterpart of the receive recirculation block. Drains the four lane FIFOs (ff0..ff3) in round-robin
//   order into one 8-bit symbol stream for the parallel-to-serial converter. Inserts IDLE symbols when every FIFO is
//   empty, a COM burst after reset, and one periodic COM symbol for receiver alignment.
// PARAMETERS
//   DATA_W        8      symbol width in bits
//   COM_SYM       8'hBC  COM (K28.5) alignment symbol
//   IDLE_SYM      8'h7C  IDLE filler symbol
//   INIT_COM      4      COM symbols emitted after reset release before any other output
//   COM_INTERVAL  16     data words between forced COM insertions (>=2)
// PORTS
//   clk          in   1       single clock, all state on posedge
//   reset        in   1       asynchronous, active-high; clears all state
//   ff_empty     in   4       per-FIFO empty flag, bit i = ff<i>
//   ff0_data     in   DATA_W  head word of ff0 (first-word-fall-through)
//   ff1_data     in   DATA_W  head word of ff1
//   ff2_data     in   DATA_W  head word of ff2
//   ff3_data     in   DATA_W  head word of ff3
//   ff_pop       out  4       one-hot pop strobe; FIFO i advances on the edge where bit i is 1
//   data_out     out  DATA_W  symbol to parallel-to-serial converter
//   valid_out    out  1       1 = data_out carries a FIFO word; 0 = COM or IDLE filler
//   k_out        out  1       1 = data_out is a control symbol (COM or IDLE)
//   lane_active  out  1       1 while FSM is in ACTIVE
// BEHAVIOUR
//   Reset (async assert, any cycle): state=INIT, init_cnt=0, com_cnt=0, rr_ptr=0, data_out=COM_SYM, valid_out=0,
//     k_out=1, lane_active=0. ff_pop is combinational and forced to 4'b0000 while reset=1.
//   FSM states:
//   - INIT: emit COM_SYM (k_out=1, valid_out=0); init_cnt++. After INIT_COM symbols go to IDLE. FIFOs are never popped
//     in INIT, even when they are non-empty.
//   - IDLE: emit IDLE_SYM (k_out=1, valid_out=0). If ff_empty != 4'hF, pop the winner this cycle and go to ACTIVE.
//   - ACTIVE: each cycle pop the round-robin winner and forward it. Exceptions: if com_cnt == COM_INTERVAL, emit
//     COM_SYM with ff_pop=0 and com_cnt=0. If ff_empty == 4'hF, emit IDLE_SYM and go to IDLE.
//   Round-robin: the winner is the first non-empty FIFO searching rr_ptr, rr_ptr+1, ... (mod 4). On a pop,
//     rr_ptr <= winner+1 (mod 4). rr_ptr holds when no pop occurs.
//   Pop/data timing: ff_pop[i] is combinational in cycle N. data_out <= ff<i>_data, valid_out <= 1, k_out <= 0 on the
//     edge ending cycle N. Latency is 1 clock from pop to output. At most one ff_pop bit is set per cycle.
//   com_cnt increments on every popped word and saturates at COM_INTERVAL. It resets to 0 after a COM insertion. It
//     keeps its value across IDLE periods and clears only on reset or COM insertion.
//   Boundaries:
//   - A FIFO going empty in the same cycle as its pop is handled by the FIFO; this block samples ff_empty only for the
//     next decision.
//   - All four FIFOs non-empty: strict rotation 0,1,2,3,0,...
//   - Single FIFO non-empty: back-to-back pops of that FIFO every cycle.
//   - A COM insertion due at the same time as all FIFOs empty: COM has priority, and IDLE follows the next cycle.
//   - Reset mid-burst: output returns to COM_SYM immediately (async). A word popped in the reset-assert cycle is lost
//     by design; the upstream FIFOs are reset by the same signal.
//   - Outputs never carry X; the default case of every case statement selects IDLE_SYM.
// TESTING
//   1. Reset, then release with ff_empty=4'hF -> 4 cycles data_out=8'hBC k_out=1, then 8'h7C continuously;
//      ff_pop stays 0.
//   2. Load ff2 only with 8'h11,8'h22, then 8'h33 -> IDLE->ACTIVE; ff_pop=4'b0100 for 3 cycles; data_out 11,22,33 one
//      cycle later with valid_out=1; then 8'h7C.
//   3. All FIFOs hold 2 words (ffN = 8'hN0,8'hN1) -> output order 00,10,20,30,01,11,21,31; rr_ptr wraps 3->0.
//   4. Continuous data stream, COM_INTERVAL=16 -> after the 16th word, one 8'hBC with ff_pop=0; the 17th word follows
//      on the next cycle.
//   5. Assert reset mid-burst (after 5 words) -> same-cycle data_out=8'hBC, valid_out=0, ff_pop=0; INIT repeats for
//      4 cycles.
//   6. Non-empty FIFOs during INIT -> no pop until INIT has emitted 4 COM symbols; first data word appears at cycle 6.

Source files
------------

// File: rtl/tx_fifo_idle_mux_if.sv
// Bundle between the four lane FIFOs, the transmit idle/COM mux and the
// parallel-to-serial converter. The mux drives as master.
interface tx_fifo_idle_mux_if #(
  parameter int DATA_W = 8
);
  // FIFO side: first-word-fall-through heads, empty flags and pop strobes
  logic [3:0]        ff_empty;
  logic [DATA_W-1:0] ff0_data;
  logic [DATA_W-1:0] ff1_data;
  logic [DATA_W-1:0] ff2_data;
  logic [DATA_W-1:0] ff3_data;
  logic [3:0]        ff_pop;
  // Serializer side: one symbol per clock, always valid as a symbol
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              k_out;
  logic              lane_active;

  // Handshake: a FIFO word is consumed on the rising edge where its ff_pop bit
  // is 1 (ff_pop is one-hot or zero, and only asserted for a non-empty FIFO);
  // that word appears on data_out with valid_out=1, k_out=0 one clock later.
  // The serializer takes data_out every cycle, there is no back-pressure.
  modport master (
    input  ff_empty, ff0_data, ff1_data, ff2_data, ff3_data,
    output ff_pop, data_out, valid_out, k_out, lane_active
  );

  modport slave (
    output ff_empty, ff0_data, ff1_data, ff2_data, ff3_data,
    input  ff_pop, data_out, valid_out, k_out, lane_active
  );
endinterface

// File: rtl/tx_fifo_idle_mux.sv
// Transmit idle/COM mux: drains four lane FIFOs round-robin into one symbol
// stream, emits a COM burst after reset, IDLE filler when all FIFOs are empty
// and a periodic COM for receiver alignment.
module tx_fifo_idle_mux #(
  parameter int              DATA_W       = 8,
  parameter logic [DATA_W-1:0] COM_SYM    = 8'hBC,
  parameter logic [DATA_W-1:0] IDLE_SYM   = 8'h7C,
  parameter int              INIT_COM     = 4,
  parameter int              COM_INTERVAL = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  tx_fifo_idle_mux_if.master   bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam int INIT_W = $clog2(INIT_COM + 1);
  localparam int COM_W  = $clog2(COM_INTERVAL + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_COM - 1);
  localparam logic [COM_W-1:0]  COM_MAX   = COM_W'(COM_INTERVAL);

  state_e              state_q, state_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic [COM_W-1:0]    com_cnt_q, com_cnt_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;
  logic                k_out_q, k_out_d;

  logic                win_found;
  logic [1:0]          win_idx;
  logic [1:0]          cand;
  logic [DATA_W-1:0]   win_data;
  logic                pop_en;

  // Round-robin search: first non-empty FIFO starting at rr_ptr
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!win_found && !bus.ff_empty[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Head word of the winning FIFO
  always_comb begin
    case (win_idx)
      2'd0:    win_data = bus.ff0_data;
      2'd1:    win_data = bus.ff1_data;
      2'd2:    win_data = bus.ff2_data;
      2'd3:    win_data = bus.ff3_data;
      default: win_data = IDLE_SYM;
    endcase
  end

  // Next-state, pop decision and next output symbol
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    com_cnt_d   = com_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    pop_en      = 1'b0;
    data_out_d  = IDLE_SYM;
    valid_out_d = 1'b0;
    k_out_d     = 1'b1;

    case (state_q)
      ST_INIT: begin
        // FIFOs are deliberately ignored until the COM burst is complete
        data_out_d = COM_SYM;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (win_found) begin
          pop_en  = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // A due COM wins over both data and the return to IDLE
        if (com_cnt_q == COM_MAX) begin
          data_out_d = COM_SYM;
          com_cnt_d  = '0;
        end else if (!win_found) begin
          state_d = ST_IDLE;
        end else begin
          pop_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop_en) begin
      data_out_d  = win_data;
      valid_out_d = 1'b1;
      k_out_d     = 1'b0;
      rr_ptr_d    = win_idx + 2'd1;
      if (com_cnt_q != COM_MAX) begin
        com_cnt_d = com_cnt_q + 1'b1;
      end
    end
  end

  // State and output registers; reset drops straight back to the COM burst
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      com_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      data_out_q  <= COM_SYM;
      valid_out_q <= 1'b0;
      k_out_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      com_cnt_q   <= com_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      k_out_q     <= k_out_d;
    end
  end

  // Pop is gated by reset so no word is consumed while the FIFOs are cleared
  assign bus.ff_pop      = (pop_en && !reset) ? 4'(4'b0001 << win_idx) : 4'b0000;
  assign bus.data_out    = data_out_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.k_out       = k_out_q;
  assign bus.lane_active = (state_q == ST_ACTIVE);
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_tx_fifo_idle_mux.sv
// Directed bench for tx_fifo_idle_mux: behavioural FWFT FIFOs feed the DUT,
// outputs are compared against hand-derived symbol sequences.
module tb_tx_fifo_idle_mux;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  tx_fifo_idle_mux_if #(.DATA_W(8)) bus ();

  tx_fifo_idle_mux #(
    .DATA_W(8), .COM_SYM(8'hBC), .IDLE_SYM(8'h7C), .INIT_COM(4), .COM_INTERVAL(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FIFO models ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];
  logic [3:0] last_pop;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.ff_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    bus.ff0_data = (q0.size() != 0) ? q0[0] : 8'h00;
    bus.ff1_data = (q1.size() != 0) ? q1[0] : 8'h00;
    bus.ff2_data = (q2.size() != 0) ? q2[0] : 8'h00;
    bus.ff3_data = (q3.size() != 0) ? q3[0] : 8'h00;
  endtask

  task automatic push(input int lane, input logic [7:0] v);
    case (lane)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
    drive();
  endtask

  task automatic clear_fifos();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    drive();
  endtask

  // One clock: capture pop mid-cycle, apply it after the edge, settle
  task automatic step();
    logic [7:0] dummy;
    @(negedge clk);
    last_pop = bus.ff_pop;
    @(posedge clk);
    #1;
    if (last_pop[0] && q0.size() != 0) dummy = q0.pop_front();
    if (last_pop[1] && q1.size() != 0) dummy = q1.pop_front();
    if (last_pop[2] && q2.size() != 0) dummy = q2.pop_front();
    if (last_pop[3] && q3.size() != 0) dummy = q3.pop_front();
    drive();
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic v, input logic k);
    check({tag, "_data"}, 32'(bus.data_out), 32'(d));
    check({tag, "_valid"}, 32'(bus.valid_out), 32'(v));
    check({tag, "_k"}, 32'(bus.k_out), 32'(k));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_fifos();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Four COM cycles with no pop, whatever the FIFOs hold
  task automatic init_burst(input string tag);
    for (int i = 0; i < 4; i++) begin
      step();
      check({tag, "_init_pop"}, 32'(last_pop), 32'h0);
      check_out({tag, "_init"}, COM, 1'b0, 1'b1);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] exp_order[8];
  logic [3:0] exp_pop[8];

  initial begin
    reset = 1'b1;
    clear_fifos();
    last_pop = 4'h0;

    // Test 1: reset values, COM burst, then IDLE with nothing popped
    apply_reset();
    push(1, 8'h99);
    #1;
    check("rst_pop", 32'(bus.ff_pop), 32'h0);
    check_out("rst", COM, 1'b0, 1'b1);
    check("rst_lane", 32'(bus.lane_active), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    clear_fifos();
    release_reset();
    init_burst("t1");
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_idle_pop", 32'(last_pop), 32'h0);
      check_out("t1_idle", IDLE, 1'b0, 1'b1);
      check("t1_lane", 32'(bus.lane_active), 32'h0);
    end

    // Test 2: only ff2 holds data, back-to-back pops of the same FIFO
    push(2, 8'h11); push(2, 8'h22); push(2, 8'h33);
    exp_order[0] = 8'h11; exp_order[1] = 8'h22; exp_order[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_pop", 32'(last_pop), 32'h4);
      check_out("t2_word", exp_order[i], 1'b1, 1'b0);
      check("t2_lane", 32'(bus.lane_active), 32'h1);
    end
    step();
    check("t2_end_pop", 32'(last_pop), 32'h0);
    check_out("t2_end", IDLE, 1'b0, 1'b1);
    check("t2_end_lane", 32'(bus.lane_active), 32'h0);

    // Test 3 + 6: all FIFOs loaded during reset; INIT must not pop, then strict rotation
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      push(n, 8'((n << 4) | 0));
      push(n, 8'((n << 4) | 1));
    end
    release_reset();
    init_burst("t3");
    exp_order = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
    exp_pop   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    for (int i = 0; i < 8; i++) begin
      step();
      check("t3_pop", 32'(last_pop), 32'(exp_pop[i]));
      check_out("t3_word", exp_order[i], 1'b1, 1'b0);
    end
    step();
    check_out("t3_end", IDLE, 1'b0, 1'b1);

    // Test 4: 20 words on ff0, COM inserted after the 16th
    apply_reset();
    for (int i = 0; i < 20; i++) push(0, 8'(8'h40 + i));
    release_reset();
    init_burst("t4");
    for (int i = 0; i < 16; i++) begin
      step();
      check("t4_pop", 32'(last_pop), 32'h1);
      check_out("t4_word", 8'(8'h40 + i), 1'b1, 1'b0);
    end
    step();
    check("t4_com_pop", 32'(last_pop), 32'h0);
    check_out("t4_com", COM, 1'b0, 1'b1);
    check("t4_com_lane", 32'(bus.lane_active), 32'h1);
    for (int i = 16; i < 20; i++) begin
      step();
      check("t4_pop2", 32'(last_pop), 32'h1);
      check_out("t4_word2", 8'(8'h40 + i), 1'b1, 1'b0);
    end
    step();
    check_out("t4_end", IDLE, 1'b0, 1'b1);

    // Test 4b: COM due exactly when FIFOs run dry, COM first then IDLE
    apply_reset();
    for (int i = 0; i < 16; i++) push(1, 8'(8'h80 + i));
    release_reset();
    init_burst("t4b");
    for (int i = 0; i < 16; i++) begin
      step();
      check_out("t4b_word", 8'(8'h80 + i), 1'b1, 1'b0);
    end
    step();
    check("t4b_com_pop", 32'(last_pop), 32'h0);
    check_out("t4b_com", COM, 1'b0, 1'b1);
    step();
    check_out("t4b_idle", IDLE, 1'b0, 1'b1);
    check("t4b_lane", 32'(bus.lane_active), 32'h0);

    // Test 5: reset asserted mid-burst after 5 words
    apply_reset();
    for (int i = 0; i < 10; i++) push(3, 8'(8'hC0 + i));
    release_reset();
    init_burst("t5");
    for (int i = 0; i < 5; i++) begin
      step();
      check_out("t5_word", 8'(8'hC0 + i), 1'b1, 1'b0);
    end
    @(negedge clk);
    check("t5_pre_pop", 32'(bus.ff_pop), 32'h8);
    reset = 1'b1;
    #1;
    check_out("t5_async", COM, 1'b0, 1'b1);
    check("t5_async_pop", 32'(bus.ff_pop), 32'h0);
    check("t5_async_lane", 32'(bus.lane_active), 32'h0);
    clear_fifos();
    release_reset();
    init_burst("t5r");
    step();
    check_out("t5_idle", IDLE, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
